// File: rtl/prio_enc_pending.sv
// Pending-request priority encoder: collects request pulses into a pending set and offers one index at a time.
// Define PRIO_ENC_RR_EN to compile in round-robin selection; the default build uses fixed highest-index priority.
module prio_enc_pending #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  output logic [W-1:0] out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic [W:0]   pend_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t       state;
  logic         accept;
  logic [N-1:0] gmask;
  logic [N-1:0] p_next;
  logic [W:0]   cnt_next;
  logic [W-1:0] sel_idx;

  // Next pending set: the accepted bit clears, but a same-cycle request for it wins.
  always_comb begin
    accept   = out_valid & out_ready;
    gmask    = accept ? (N'(1) << out_idx) : '0;
    p_next   = (pending & ~gmask) | req_i;
    cnt_next = '0;
    for (int i = 0; i < N; i++) begin
      cnt_next = cnt_next + (W+1)'(p_next[i]);
    end
  end

`ifdef PRIO_ENC_RR_EN
  logic [W-1:0] rr_ptr;
  logic [W-1:0] rr_base;

  // Search downward from rr_base-1 with wrap; the pointer updates on accept, so the
  // search for the next offer already starts below the index just granted.
  always_comb begin
    rr_base = accept ? out_idx : rr_ptr;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel_idx = '0;
    for (int i = N; i >= 1; i--) begin
      if (p_next[W'(rr_base - W'(i))]) sel_idx = W'(rr_base - W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= out_idx;
    end
  end
`else
  // Fixed priority: the highest set index wins (later iterations override earlier ones).
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (p_next[i]) sel_idx = W'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
      pending   <= '0;
      pend_cnt  <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      pending  <= p_next;
      pend_cnt <= cnt_next;
      case (state)
        IDLE: begin
          if (p_next != '0) begin
            out_idx   <= sel_idx;
            out_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          // Without accept the offer holds; a newer higher-priority request never preempts it.
          if (accept) begin
            if (p_next != '0) begin
              out_idx <= sel_idx;
            end else begin
              out_idx   <= '0;
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_enc_pending.sv
// Self-checking bench for prio_enc_pending: N=4 instance against a behavioural model, plus an N=8 instance.
module tb_prio_enc_pending;

  logic       clk;
  logic       rst_n;
  logic [3:0] req4;
  logic       rdy4;
  logic [1:0] idx4;
  logic       vld4;
  logic [3:0] pend4;
  logic [2:0] cnt4;

  logic [7:0] req8;
  logic       rdy8;
  logic [2:0] idx8;
  logic       vld8;
  logic [7:0] pend8;
  logic [3:0] cnt8;

  int total = 0;
  int bad   = 0;

  prio_enc_pending #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_i(req4), .out_idx(idx4), .out_valid(vld4),
    .out_ready(rdy4), .pending(pend4), .pend_cnt(cnt4)
  );

  prio_enc_pending #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req_i(req8), .out_idx(idx8), .out_valid(vld8),
    .out_ready(rdy8), .pending(pend8), .pend_cnt(cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of the N=4 instance: a set of outstanding indices and the current offer.
  typedef struct packed {
    logic [3:0] pend;
    logic       valid;
    logic [1:0] idx;
    logic [1:0] ptr;
  } mstate_t;

  mstate_t m;

  function automatic int pick(input logic [3:0] p, input int ptr);
`ifdef PRIO_ENC_RR_EN
    for (int s = 1; s <= 4; s++) begin
      int k;
      k = (ptr - s + 8) % 4;
      if (p[k]) return k;
    end
`else
    for (int k = 3; k >= 0; k--) begin
      if (p[k]) return k;
    end
`endif
    return 0;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input logic [3:0] req, input logic rdy);
    mstate_t    n;
    logic       acc;
    logic [3:0] p;
    acc = s.valid && rdy;
    p   = s.pend;
    if (acc) p[s.idx] = 1'b0;
    p      = p | req;
    n      = s;
    n.pend = p;
    if (acc) n.ptr = s.idx;
    if (!s.valid || acc) begin
      if (p == 4'b0000) begin
        n.valid = 1'b0;
        n.idx   = 2'd0;
      end else begin
        n.valid = 1'b1;
        n.idx   = 2'(pick(p, int'(n.ptr)));
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_step(m, req4, rdy4);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_valid", 32'(vld4), 32'(m.valid));
      check("model_idx", 32'(idx4), 32'(m.idx));
      check("model_pending", 32'(pend4), 32'(m.pend));
      check("model_cnt", 32'(cnt4), 32'($countones(m.pend)));
    end
  end

  int exp_seq[8];

  initial begin
    rst_n = 1'b0;
    req4  = '0;
    rdy4  = 1'b0;
    req8  = '0;
    rdy8  = 1'b0;
    #2;
    check("reset_valid", 32'(vld4), 32'd0);
    check("reset_pending", 32'(pend4), 32'd0);
    check("reset_cnt", 32'(cnt4), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // All four requested in one pulse, consumer always ready: drains 3,2,1,0.
    req4 = 4'b1111;
    rdy4 = 1'b1;
    tick();
    req4 = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      check("burst_valid", 32'(vld4), 32'd1);
      check("burst_idx", 32'(idx4), 32'(3 - k));
      check("burst_cnt", 32'(cnt4), 32'(4 - k));
      tick();
    end
    check("burst_end_valid", 32'(vld4), 32'd0);
    check("burst_end_cnt", 32'(cnt4), 32'd0);

    // Stall: offer 0 holds while a higher request arrives.
    rdy4 = 1'b0;
    req4 = 4'b0001;
    tick();
    req4 = 4'b1000;
    tick();
    req4 = 4'b0000;
    tick();
    check("stall_idx", 32'(idx4), 32'd0);
    check("stall_valid", 32'(vld4), 32'd1);
    check("stall_pending", 32'(pend4), 32'b1001);
    rdy4 = 1'b1;
    tick();
    check("stall_next_idx", 32'(idx4), 32'd3);
    check("stall_next_pending", 32'(pend4), 32'b1000);
    tick();
    check("stall_drain_valid", 32'(vld4), 32'd0);

    // Re-request of the accepted index in the accept cycle keeps it pending.
    rdy4 = 1'b0;
    req4 = 4'b0100;
    tick();
    check("rereq_first_idx", 32'(idx4), 32'd2);
    rdy4 = 1'b1;
    tick();
    check("rereq_pending", 32'(pend4), 32'b0100);
    check("rereq_idx", 32'(idx4), 32'd2);
    check("rereq_valid", 32'(vld4), 32'd1);
    req4 = 4'b0000;
    tick();
    check("rereq_drain_valid", 32'(vld4), 32'd0);

    // Reset mid-offer: outputs clear immediately and requests are ignored while low.
    rdy4 = 1'b0;
    req4 = 4'b0100;
    tick();
    check("pre_reset_idx", 32'(idx4), 32'd2);
    req4 = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(vld4), 32'd0);
    check("async_reset_idx", 32'(idx4), 32'd0);
    check("async_reset_pending", 32'(pend4), 32'd0);
    check("async_reset_cnt", 32'(cnt4), 32'd0);
    req4 = 4'b1111;
    tick();
    check("in_reset_pending", 32'(pend4), 32'd0);
    check("in_reset_valid", 32'(vld4), 32'd0);
    req4 = 4'b0000;
    #2 rst_n = 1'b1;
    tick();
    check("post_reset_valid", 32'(vld4), 32'd0);

    // Held all-ones with ready: round-robin rotates, fixed priority sticks at 3.
`ifdef PRIO_ENC_RR_EN
    exp_seq = '{3, 2, 1, 0, 3, 2, 1, 0};
`else
    exp_seq = '{3, 3, 3, 3, 3, 3, 3, 3};
`endif
    req4 = 4'b1111;
    rdy4 = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      check("held_idx", 32'(idx4), 32'(exp_seq[k]));
      tick();
    end
    req4 = 4'b0000;
    tick();
    tick();
    tick();
    tick();
    tick();
    check("held_drain_valid", 32'(vld4), 32'd0);

    // N=8 saturation: full count, stable top index.
    req8 = 8'hFF;
    rdy8 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("n8_cnt", 32'(cnt8), 32'd8);
      check("n8_idx", 32'(idx8), 32'd7);
      check("n8_valid", 32'(vld8), 32'd1);
      check("n8_pending", 32'(pend8), 32'hFF);
    end
    req8 = 8'h00;

    // Randomised traffic checked cycle by cycle against the model.
    for (int c = 0; c < 2000; c++) begin
      req4 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      rdy4 = (c % 200 < 60) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (c == 1100) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prio_enc_pending.md
PRIO_ENC_PENDING -- requirements
Module: prio_enc_pending

Interface
REQ-001 SHALL have parameter N, default 8, number of request lines, power of two, N >= 2.
REQ-002 SHALL derive local parameter W = $clog2(N), the index width; W is not overridable.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_i  input  N  request pulses; bit i set = request for index i, sampled every edge.
REQ-007 out_idx  output  W  encoded index currently offered.
REQ-008 out_valid  output  1  out_idx holds a valid offer.
REQ-009 out_ready  input  1  consumer accepts the offer when high with out_valid.
REQ-010 pending  output  N  registered set of outstanding requests, offered bit included.
REQ-011 pend_cnt  output  W+1  population count of pending.

Function
REQ-012 SHALL define accept = out_valid & out_ready, and gmask = onehot(out_idx) when accept, else 0.
REQ-013 SHALL define P' = (pending & ~gmask) | req_i; pending <= P' every edge.
REQ-014 A req_i bit for an index already pending SHALL merge silently, one outstanding request per index.
REQ-015 Re-requesting the accepted index in the accept cycle SHALL leave that bit set: req_i wins over the clear.
REQ-016 SHALL be a two-state FSM: IDLE (out_valid=0) and OFFER (out_valid=1).
REQ-017 In IDLE with P' != 0: out_idx <= sel(P'), go to OFFER; latency is one edge from req_i sample to out_valid.
REQ-018 In OFFER without accept: out_idx and out_valid SHALL hold; a later higher-priority request does not preempt.
REQ-019 In OFFER with accept and P' != 0: out_idx <= sel(P'), stay in OFFER; back-to-back offers, no bubble.
REQ-020 In OFFER with accept and P' == 0: out_valid <= 0, out_idx <= 0, go to IDLE.
REQ-021 Fixed mode: sel(x) SHALL return the index of the highest set bit of x.
REQ-022 pend_cnt SHALL be registered alongside pending, equal to popcount(P'); all-ones gives N, no overflow.
REQ-023 No output SHALL have a combinational path from req_i or out_ready.

Reset
REQ-024 rst_n low SHALL immediately, without a clock edge, force pending=0, pend_cnt=0, out_valid=0, out_idx=0, FSM=IDLE, and the RR pointer to 0.
REQ-025 Reset mid-offer SHALL discard the offer and all pending requests; req_i is ignored while rst_n is low.
REQ-026 Deassertion SHALL be synchronised externally; the first edge after release behaves as IDLE.

Configuration
REQ-027 Macro PRIO_ENC_RR_EN, when defined, SHALL compile in round-robin selection with a W-bit pointer rr_ptr, reset value 0.
REQ-028 With PRIO_ENC_RR_EN, sel(x) SHALL search downward from (rr_ptr-1) mod N with wrap and return the first set bit; on accept, rr_ptr <= out_idx.
REQ-029 rr_ptr=0 SHALL give the order N-1..0, identical to fixed mode.
REQ-030 Without PRIO_ENC_RR_EN, no pointer SHALL exist and fixed highest-index priority applies.

Verification (N=4 unless stated)
REQ-031 Reset: rst_n=0 mid-OFFER with out_idx=2 -> out_valid=0, out_idx=0, pending=0000, pend_cnt=0 before the next clock edge.
REQ-032 req_i=1111 for one cycle, out_ready=1 held -> out_idx 3,2,1,0 on four consecutive cycles with out_valid=1, then out_valid=0; pend_cnt 4,3,2,1,0.
REQ-033 Stall: req_i=0001, out_ready=0, then a req_i=1000 pulse -> out_idx stays 0, pending=1001; raise out_ready -> out_idx=0 accepted, next cycle out_idx=3.
REQ-034 Accept of index 2 with req_i=0100 in the same cycle -> pending bit 2 remains set and index 2 is offered again next cycle.
REQ-035 req_i=1111 held, out_ready=1: with PRIO_ENC_RR_EN -> out_idx 3,2,1,0,3,2...; without -> 3,3,3...
REQ-036 N=8, req_i=8'hFF held, out_ready=0 -> pend_cnt=8, out_idx=7 stable, no wrap or overflow.
